uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter_if.sv | 9 +
 rtl/uart_transmitter.sv | 75 +++++++
 tb/tb_uart_transmitter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: byte handshake and serial line of uart_transmitter
interface uart_transmitter_if;
   logic [7:0] DataIn;
   logic       DataInValid;
   logic       DataInReady;
   logic       SOut;
   modport master (output DataIn, DataInValid, input DataInReady, SOut);
   modport slave (input DataIn, DataInValid, output DataInReady, SOut);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: start + 8 data (LSB first) + stop serializer, N = CLOCK_FREQ/BAUD_RATE cycles per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmitter #(
   parameter int CLOCK_FREQ = 33_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input logic Clock,
   input logic Reset,
   uart_transmitter_if.slave tx
);
   localparam int N = CLOCK_FREQ / BAUD_RATE;
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam state_t AFTER_DATA = PARITY;
   logic par;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
   localparam state_t AFTER_DATA = STOP;
`endif
   state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic [2:0] bit_idx;
   logic [7:0] sh, sh_nxt;
   logic accept, tick, sout_nxt;
   assign accept = tx.DataInValid && state == IDLE;
   assign tick = cnt == LAST;
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         sh      <= '0;
         tx.SOut <= 1'b1;
      end else begin
         state   <= state_nxt;
         cnt     <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
         bit_idx <= (state == DATA && tick) ? bit_idx + 1'b1 : bit_idx;
         sh      <= sh_nxt;
         tx.SOut <= sout_nxt;
      end
   end
`ifdef UART_TX_PARITY_EN
   // parity is taken at accept because the shift register is consumed during DATA
   always_ff @(posedge Clock) begin
      if (Reset) par <= 1'b0;
      else if (accept) par <= ^tx.DataIn;
   end
`endif
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   state_nxt = accept ? START : IDLE;
         START:  state_nxt = tick ? DATA : START;
         DATA:   state_nxt = (tick && bit_idx == 3'd7) ? AFTER_DATA : DATA;
`ifdef UART_TX_PARITY_EN
         PARITY: state_nxt = tick ? STOP : PARITY;
`endif
         STOP:   state_nxt = tick ? IDLE : STOP;
         default: state_nxt = IDLE;
      endcase
   end
   // SOut is registered from the next state so the line changes on the same edge as the FSM
   always_comb begin
      tx.DataInReady = state == IDLE;
      sh_nxt = accept ? tx.DataIn : (state == DATA && tick) ? sh >> 1 : sh;
      sout_nxt = 1'b1;
      if (state_nxt == START) sout_nxt = 1'b0;
      else if (state_nxt == DATA) sout_nxt = sh_nxt[0];
`ifdef UART_TX_PARITY_EN
      else if (state_nxt == PARITY) sout_nxt = par;
`endif
   end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: randomized bench; a cycle-level line model and a frame scoreboard check uart_transmitter.
// Define UART_TX_PARITY_EN for both bench and design to exercise the parity frame.
module tb_uart_transmitter;
   localparam int N = 10;
`ifdef UART_TX_PARITY_EN
   localparam int F = 11;
`else
   localparam int F = 10;
`endif
   logic Clock = 1'b0;
   logic Reset = 1'b1;
   uart_transmitter_if tx();
   uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (.Clock(Clock), .Reset(Reset), .tx(tx));
   always #5 Clock = ~Clock;
   int checks = 0, failures = 0, cyc = 0, acc_cnt = 0, low_run = 0, k = 0;
   bit line_q[$];
   logic [7:0] byte_q[$];
   int dut_acc[$];
   bit rst_seen = 1'b0, aborted = 1'b0, dec_on = 1'b0;
   logic [7:0] m_d, rx;
   function automatic void check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
      end
   endfunction
   // reference: on accept the whole frame is queued as one expected line level per cycle
   always @(posedge Clock) begin
      if (Reset) begin
         line_q.delete();
         byte_q.delete();
         rst_seen = 1'b1;
         aborted = 1'b1;
      end else if (line_q.size() == 0) begin
         if (tx.DataInValid) begin
            m_d = tx.DataIn;
            for (int i = 0; i < F; i++) begin
               bit b;
               if (i == 0) b = 1'b0;
               else if (i <= 8) b = m_d[i-1];
               else if (F == 11 && i == 9) b = ^m_d;
               else b = 1'b1;
               repeat (N) line_q.push_back(b);
            end
            byte_q.push_back(m_d);
            acc_cnt++;
         end
      end else void'(line_q.pop_front());
   end
   always @(negedge Clock) begin
      cyc++;
      check("sout", tx.SOut, line_q.size() != 0 ? int'(line_q[0]) : 1);
      check("ready", tx.DataInReady, line_q.size() == 0);
      if (tx.DataInValid && tx.DataInReady && !Reset) dut_acc.push_back(cyc);
      if (!tx.DataInReady) low_run++;
      else begin
         if (low_run != 0 && !aborted) check("ready_low_len", low_run, N * F);
         low_run = 0;
         aborted = 1'b0;
      end
      if (rst_seen) begin
         dec_on = 1'b0;
         rst_seen = 1'b0;
      end else if (!dec_on) begin
         if (!tx.SOut) begin
            dec_on = 1'b1;
            k = 0;
         end
      end else k++;
      if (dec_on) begin
         if (k == N / 2) check("start_bit", tx.SOut, 0);
         if (k >= N && k < 9 * N && k % N == N / 2) rx[k/N-1] = tx.SOut;
`ifdef UART_TX_PARITY_EN
         if (k == 9 * N + N / 2) check("parity_bit", tx.SOut, ^rx);
`endif
         if (k == (F - 1) * N + N / 2) begin
            check("stop_bit", tx.SOut, 1);
            check("frame_expected", byte_q.size() != 0, 1);
            if (byte_q.size() != 0) check("frame_byte", rx, byte_q.pop_front());
            dec_on = 1'b0;
         end
      end
   end
   task automatic step();
      @(posedge Clock);
      #1;
   endtask
   task automatic wait_acc(input int c0);
      int t = 0;
      while (acc_cnt == c0 && t < 3000) begin
         step();
         t++;
      end
      check("accept_seen", acc_cnt != c0, 1);
   endtask
   task automatic send(input logic [7:0] d);
      int c0 = acc_cnt;
      tx.DataInValid = 1'b1;
      tx.DataIn = d;
      wait_acc(c0);
      tx.DataInValid = 1'b0;
   endtask
   task automatic churn(input bit junk);
      int t = 0;
      while (line_q.size() > 1 && t < 3000) begin
         tx.DataIn = 8'($urandom);
         if (junk) tx.DataInValid = 1'($urandom_range(0, 1));
         step();
         t++;
      end
      tx.DataInValid = 1'b0;
   endtask
   task automatic wait_frame();
      int t = 0;
      while (line_q.size() != 0 && t < 3000) begin
         step();
         t++;
      end
      check("frame_done", line_q.size(), 0);
   endtask
   initial begin
      int c0, sz;
      tx.DataIn = 8'h00;
      tx.DataInValid = 1'b0;
      repeat (3) step();
      Reset = 1'b0;
      repeat (20) step();
      send(8'hA5);
      wait_frame();
      send(8'h07);
      wait_frame();
      c0 = acc_cnt;
      tx.DataInValid = 1'b1;
      tx.DataIn = 8'h55;
      wait_acc(c0);
      tx.DataIn = 8'hAA;
      c0 = acc_cnt;
      wait_acc(c0);
      tx.DataInValid = 1'b0;
      churn(1'b0);
      wait_frame();
      sz = dut_acc.size();
      if (sz >= 2) check("accept_gap", dut_acc[sz-1] - dut_acc[sz-2], N * F + 1);
      else check("accept_count", sz, 2);
      send(8'hFF);
      repeat (44) step();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      repeat (3) step();
      send(8'h3C);
      wait_frame();
      tx.DataInValid = 1'b1;
      tx.DataIn = 8'($urandom);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      tx.DataInValid = 1'b0;
      repeat (20) step();
      for (int f = 0; f < 15; f++) begin
         repeat ($urandom_range(0, 5)) step();
         send(8'($urandom));
         churn(1'b1);
         wait_frame();
      end
      repeat (5) step();
      check("scoreboard_empty", byte_q.size(), 0);
      check("decoder_idle", dec_on, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
